// File: rtl/rptr_empty_if.sv
// Read-side FIFO port bundle: consumer read request, write pointer from the write
// side, and the read pointer, flags and read-data-valid strobe from rptr_empty.
// The underflow signal exists only when RPTR_UNDERFLOW_FLAG_EN is defined.
interface rptr_empty_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic                  empty;
    logic                  almost_empty;
    logic [ADDR_WIDTH-1:0] rd_count;
    logic                  rd_valid;
`ifdef RPTR_UNDERFLOW_FLAG_EN
    logic                  underflow;
`endif

    // Consumer / write-side view: drives the request and the write pointer.
    modport master (
        output rd_en,
        output wptr,
        input  rptr,
        input  empty,
        input  almost_empty,
        input  rd_count,
`ifdef RPTR_UNDERFLOW_FLAG_EN
        input  underflow,
`endif
        input  rd_valid
    );

    // Read-pointer block view.
    modport slave (
        input  rd_en,
        input  wptr,
        output rptr,
        output empty,
        output almost_empty,
        output rd_count,
`ifdef RPTR_UNDERFLOW_FLAG_EN
        output underflow,
`endif
        output rd_valid
    );
endinterface

// File: rtl/rptr_empty.sv
// rptr_empty: read pointer and empty detection for a power-of-two synchronous FIFO.
// Owns the binary read pointer, which doubles as the RAM read address. It compares
// that pointer against the write pointer to produce empty, almost_empty and the
// occupancy count. It also produces rd_valid, which is aligned to the RAM's
// registered read port.
// Optional feature: define RPTR_UNDERFLOW_FLAG_EN to get a sticky underflow flag.
module rptr_empty #(
    parameter int ADDR_WIDTH    = 4,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic         clk,
    input  logic         rst,
    rptr_empty_if.slave  rd_bus
);
    localparam logic [ADDR_WIDTH-1:0] L_ONE    = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] L_THRESH = ADDR_WIDTH'(AEMPTY_THRESH);

    logic [ADDR_WIDTH-1:0] r_rptr;
    logic                  r_rd_valid;
    logic [ADDR_WIDTH-1:0] w_rd_count;
    logic                  w_empty;
    logic                  w_almost_empty;
    logic                  w_accept;

    // Flags are pure functions of the two pointers; the modular difference never
    // reaches DEPTH because the write side stops one slot short of full.
    always_comb begin
        w_rd_count     = rd_bus.wptr - r_rptr;
        w_empty        = (r_rptr == rd_bus.wptr);
        w_almost_empty = (w_rd_count <= L_THRESH);
        if (rd_bus.rd_en && !w_empty) begin
            w_accept = 1'b1;
        end else begin
            w_accept = 1'b0;
        end
    end

    // Read pointer: advance on an accepted read, wrapping naturally in ADDR_WIDTH bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rptr <= '0;
        end else if (w_accept) begin
            r_rptr <= r_rptr + L_ONE;
        end
    end

    // Read-data-valid: one cycle behind the accept, matching the RAM read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_accept;
        end
    end

`ifdef RPTR_UNDERFLOW_FLAG_EN
    logic r_underflow;

    // Sticky underflow: any read request against an empty FIFO latches it until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_underflow <= 1'b0;
        end else if (rd_bus.rd_en && w_empty) begin
            r_underflow <= 1'b1;
        end
    end

    assign rd_bus.underflow = r_underflow;
`endif

    assign rd_bus.rptr         = r_rptr;
    assign rd_bus.rd_valid     = r_rd_valid;
    assign rd_bus.empty        = w_empty;
    assign rd_bus.almost_empty = w_almost_empty;
    assign rd_bus.rd_count     = w_rd_count;

endmodule

// File: tb/tb_rptr_empty.sv
// Self-checking bench for rptr_empty (ADDR_WIDTH=4, AEMPTY_THRESH=2).
// The reference model counts accepted reads and derives occupancy with integer
// arithmetic. A negedge compare process checks every output against it. Directed
// scenarios add literal expectations, and a randomized phase follows them.
module tb_rptr_empty;
    localparam int AW     = 4;
    localparam int DEPTH  = 16;
    localparam int THRESH = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    bit   started = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    rptr_empty_if #(.ADDR_WIDTH(AW)) bus ();

    rptr_empty #(.ADDR_WIDTH(AW), .AEMPTY_THRESH(THRESH)) dut (
        .clk    (clk),
        .rst    (rst),
        .rd_bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model state.
    int m_rptr  = 0;
    bit m_valid = 1'b0;
    bit m_uf    = 1'b0;

    function automatic int occ_of(int w, int r);
        return (w - r + DEPTH) % DEPTH;
    endfunction

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model update: a read is taken when requested and the model FIFO holds data.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rptr  <= 0;
            m_valid <= 1'b0;
            m_uf    <= 1'b0;
        end else begin
            if (bus.rd_en && occ_of(int'(bus.wptr), m_rptr) != 0) begin
                m_rptr  <= (m_rptr + 1) % DEPTH;
                m_valid <= 1'b1;
            end else begin
                m_valid <= 1'b0;
            end
            if (bus.rd_en && occ_of(int'(bus.wptr), m_rptr) == 0) m_uf <= 1'b1;
        end
    end

    // Compare every output against the model each cycle, away from the clock edge.
    always @(negedge clk) begin
        if (started) begin
            int occ;
            occ = occ_of(int'(bus.wptr), m_rptr);
            check("rptr",         int'(bus.rptr),         m_rptr);
            check("empty",        int'(bus.empty),        int'(occ == 0));
            check("almost_empty", int'(bus.almost_empty), int'(occ <= THRESH));
            check("rd_count",     int'(bus.rd_count),     occ);
            check("rd_valid",     int'(bus.rd_valid),     int'(m_valid));
`ifdef RPTR_UNDERFLOW_FLAG_EN
            check("underflow",    int'(bus.underflow),    int'(m_uf));
`endif
        end
    end

    // Drive point: 2 time units after the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic read_cycles(int n);
        bus.rd_en = 1'b1;
        repeat (n) step();
        bus.rd_en = 1'b0;
    endtask

    initial begin
        int nv;
        bus.rd_en = 1'b0;
        bus.wptr  = '0;

        // 1. Reset
        #1 rst = 1'b1;
        started = 1'b1;
        step();
        step();
        #1;
        check("rst_rptr",  int'(bus.rptr),         0);
        check("rst_empty", int'(bus.empty),        1);
        check("rst_aempt", int'(bus.almost_empty), 1);
        check("rst_count", int'(bus.rd_count),     0);
        check("rst_valid", int'(bus.rd_valid),     0);
        rst = 1'b0;

        // 2. Fill to 5, then request 6 reads
        step();
        for (int i = 1; i <= 5; i++) begin
            bus.wptr = AW'(i);
            step();
        end
        bus.rd_en = 1'b1;
        nv = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i == 6) bus.rd_en = 1'b0;
            if (bus.rd_valid) nv++;
        end
        step();
        check("drain_valid_cycles", nv, 5);
        check("drain_rptr",  int'(bus.rptr),  5);
        check("drain_empty", int'(bus.empty), 1);

        // 3. Wrap: bring rptr to 14, then wptr=2
        bus.wptr = AW'(14);
        step();
        read_cycles(9);
        bus.wptr = AW'(2);
        #1;
        check("wrap_rptr14", int'(bus.rptr),     14);
        check("wrap_count4", int'(bus.rd_count), 4);
        step();
        read_cycles(4);
        #1;
        check("wrap_rptr_end", int'(bus.rptr),     2);
        check("wrap_empty",    int'(bus.empty),    1);
        check("wrap_count0",   int'(bus.rd_count), 0);

        // 4. Full occupancy: rptr=3, wptr=2
        bus.wptr = AW'(3);
        step();
        read_cycles(1);
        bus.wptr = AW'(2);
        #1;
        check("full_count", int'(bus.rd_count),     15);
        check("full_empty", int'(bus.empty),        0);
        check("full_aempt", int'(bus.almost_empty), 0);
        read_cycles(1);
        #1;
        check("full_rptr4",   int'(bus.rptr),     4);
        check("full_count14", int'(bus.rd_count), 14);

        // 5. Same-cycle: empty at 7, read requested while write advances to 8
        bus.wptr = AW'(7);
        step();
        read_cycles(3);
        bus.rd_en = 1'b1;
        step();
        bus.wptr = AW'(8);
        #1;
        check("same_noacc_rptr",  int'(bus.rptr),     7);
        check("same_noacc_valid", int'(bus.rd_valid), 0);
        step();
        bus.rd_en = 1'b0;
        #1;
        check("same_acc_rptr",  int'(bus.rptr),     8);
        check("same_acc_valid", int'(bus.rd_valid), 1);

`ifdef RPTR_UNDERFLOW_FLAG_EN
        // 6. Underflow is sticky through later valid reads
        step();
        read_cycles(1);
        #1;
        check("uf_set", int'(bus.underflow), 1);
        bus.wptr = AW'(10);
        step();
        read_cycles(2);
        #1;
        check("uf_hold", int'(bus.underflow), 1);
`endif

        // Asynchronous reset mid-cycle while a read is in flight
        bus.wptr = AW'(12);
        step();
        bus.rd_en = 1'b1;
        step();
        #1;
        rst = 1'b1;
        bus.wptr = '0;
        bus.rd_en = 1'b0;
        #1;
        check("arst_rptr",  int'(bus.rptr),     0);
        check("arst_valid", int'(bus.rd_valid), 0);
        check("arst_empty", int'(bus.empty),    1);
`ifdef RPTR_UNDERFLOW_FLAG_EN
        check("arst_uf",    int'(bus.underflow), 0);
`endif
        step();
        rst = 1'b0;

        // Randomized traffic; the write side never exceeds DEPTH-1 entries
        for (int c = 0; c < 3000; c++) begin
            step();
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                bus.wptr = '0;
                bus.rd_en = 1'b0;
                step();
                rst = 1'b0;
            end else begin
                bus.rd_en = ($urandom_range(0, 99) < 55);
                if ($urandom_range(0, 99) < 50 && occ_of(int'(bus.wptr), m_rptr) < DEPTH - 1)
                    bus.wptr = bus.wptr + AW'(1);
            end
        end
        bus.rd_en = 1'b0;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
